exec_stage_md: RTL

- Parametrised next-generation execute stage for the RISC-V pipeline.
- Combinational datapath:
  - ALU path with MEM/WB forwarding.
  - Branch/jump resolution on forwarded operand values; signed and unsigned compares are done on data, not on register indices.
  - Branch/jump target = pc + imm.
- Sequential: an iterative RV32M multiply/divide unit that stalls the pipeline while busy.
- Sits between the ID/EX and EX/MEM registers. Drives the hazard unit's stall input and the fetch redirect.

---
 rtl/riscv_ex_pkg.sv | 46 ++++
 rtl/alu.sv | 39 +++
 rtl/md_unit.sv | 170 +++++++++++++++++
 rtl/exec_stage_md.sv | 105 ++++++++++
 4 files changed

// File: rtl/riscv_ex_pkg.sv
// Shared types and encodings for the execute stage: mul/div FSM states,
// forwarding selects, funct3 codes and ALU operation codes.
package riscv_ex_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // bit1 (MEM) outranks bit0 (WB); 2'b11 therefore also selects MEM.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_SLL   = 2;
  localparam int ALU_SLT   = 3;
  localparam int ALU_SLTU  = 4;
  localparam int ALU_XOR   = 5;
  localparam int ALU_SRL   = 6;
  localparam int ALU_SRA   = 7;
  localparam int ALU_OR    = 8;
  localparam int ALU_AND   = 9;
  localparam int ALU_PASSB = 10;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU used by the execute stage.
module alu
  import riscv_ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 5
) (
  input  logic [ALU_OP_W-1:0] i_op,
  input  logic [XLEN-1:0]     i_a,
  input  logic [XLEN-1:0]     i_b,
  output logic [XLEN-1:0]     o_y
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] w_shamt;

  assign w_shamt = i_b[SH_W-1:0];

  // Operation select; unknown codes yield zero
  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_OP_W'(ALU_ADD):   o_y = i_a + i_b;
      ALU_OP_W'(ALU_SUB):   o_y = i_a - i_b;
      ALU_OP_W'(ALU_SLL):   o_y = i_a << w_shamt;
      ALU_OP_W'(ALU_SLT):   o_y = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      ALU_OP_W'(ALU_SLTU):  o_y = {{(XLEN-1){1'b0}}, i_a < i_b};
      ALU_OP_W'(ALU_XOR):   o_y = i_a ^ i_b;
      ALU_OP_W'(ALU_SRL):   o_y = i_a >> w_shamt;
      ALU_OP_W'(ALU_SRA):   o_y = $signed(i_a) >>> w_shamt;
      ALU_OP_W'(ALU_OR):    o_y = i_a | i_b;
      ALU_OP_W'(ALU_AND):   o_y = i_a & i_b;
      ALU_OP_W'(ALU_PASSB): o_y = i_b;
      default:              o_y = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Iterative radix-2 RV32M multiply/divide unit.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on start
//   BUSY  | one shift-add / shift-subtract step per cycle, XLEN steps
//   DONE  | r_result holds the signed-corrected answer for one cycle
//
// Divide-by-zero and signed overflow skip BUSY and go straight to DONE.
module md_unit
  import riscv_ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t           r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic [XLEN-1:0]     r_result;
  logic [2:0]          r_f3;
  logic                r_neg;
  logic                r_neg_rem;

  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_abs;
  logic [XLEN-1:0]     w_b_abs;
  logic                w_is_div;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic [XLEN-1:0]     w_special;
  logic [XLEN:0]       w_add;
  logic [XLEN:0]       w_sub;
  logic [2*XLEN-1:0]   w_acc_step;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_fix;

  // Operand signedness per funct3; MUL takes the low half so it is treated as unsigned
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (i_funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      F3_MULHSU: w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_a_neg    = w_a_signed & i_a[XLEN-1];
  assign w_b_neg    = w_b_signed & i_b[XLEN-1];
  assign w_a_abs    = w_a_neg ? -i_a : i_a;
  assign w_b_abs    = w_b_neg ? -i_b : i_b;
  assign w_is_div   = i_funct3[2];
  assign w_div_zero = w_is_div & (i_b == '0);
  assign w_div_ovf  = w_is_div & ~i_funct3[0] & (i_a == MOST_NEG) & (i_b == '1);

  // Short-circuit answers: x/0 -> all ones, x%0 -> x; MIN/-1 -> MIN, MIN%-1 -> 0
  always_comb begin
    w_special = i_a;
    if (w_div_zero) begin
      w_special = i_funct3[1] ? i_a : '1;
    end else if (i_funct3[1]) begin
      w_special = '0;
    end
  end

  // One iteration: multiply adds into the high half then shifts right;
  // divide shifts the remainder left and subtracts if it does not borrow
  always_comb begin
    w_add = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
    w_sub = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
    if (r_f3[2]) begin
      if (w_sub[XLEN]) begin
        w_acc_step = {r_acc[2*XLEN-2:0], 1'b0};
      end else begin
        w_acc_step = {w_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end
    end else if (r_acc[0]) begin
      w_acc_step = {w_add, r_acc[XLEN-1:1]};
    end else begin
      w_acc_step = {1'b0, r_acc[2*XLEN-1:1]};
    end
  end

  // Sign fix-up of the final iteration's value; remainder takes the dividend's sign
  always_comb begin
    w_prod = r_neg ? -w_acc_step : w_acc_step;
    w_quo  = r_neg ? -w_acc_step[XLEN-1:0] : w_acc_step[XLEN-1:0];
    w_rem  = r_neg_rem ? -w_acc_step[2*XLEN-1:XLEN] : w_acc_step[2*XLEN-1:XLEN];
    case (r_f3)
      F3_MUL:                       w_fix = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_fix = w_quo;
      default:                      w_fix = w_rem;
    endcase
  end

  // FSM, iteration counter, accumulator and result register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_result  <= '0;
      r_f3      <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (i_flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_f3      <= i_funct3;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= LAST_CNT;
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_special;
              r_state  <= DONE;
            end else begin
              r_opnd  <= w_is_div ? w_b_abs : w_a_abs;
              r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_a_abs : w_b_abs)};
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_acc <= w_acc_step;
          if (r_cnt == '0) begin
            r_result <= w_fix;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy   = ((r_state == IDLE) && i_start) || (r_state == BUSY);
  assign o_done   = (r_state == DONE);
  assign o_result = r_result;

endmodule

// File: rtl/exec_stage_md.sv
// Execute stage: forwarding, ALU, branch resolution and the iterative
// mul/div unit, which stalls the pipeline while it works.
module exec_stage_md
  import riscv_ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 5,
  parameter int CNT_W    = $clog2(XLEN) + 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid_in,
  input  logic                i_flush,
  input  logic [XLEN-1:0]     i_pc,
  input  logic [XLEN-1:0]     i_pc_plus4,
  input  logic [2:0]          i_funct3,
  input  logic                i_branch,
  input  logic                i_jump,
  input  logic                i_md_op,
  input  logic [1:0]          i_alu_src_b_sel,
  input  logic [ALU_OP_W-1:0] i_alu_op,
  input  logic [XLEN-1:0]     i_rs1_data,
  input  logic [XLEN-1:0]     i_rs2_data,
  input  logic [XLEN-1:0]     i_imm,
  input  logic [1:0]          i_fwd_a,
  input  logic [1:0]          i_fwd_b,
  input  logic [XLEN-1:0]     i_fwd_mem_data,
  input  logic [XLEN-1:0]     i_fwd_wb_data,
  output logic                o_stall,
  output logic                o_valid_out,
  output logic                o_pc_next_sel,
  output logic [XLEN-1:0]     o_branch_jump_addr,
  output logic [XLEN-1:0]     o_result,
  output logic [XLEN-1:0]     o_write_data
);

  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b_raw;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_cond;
  logic            w_md_start;
  logic            w_md_busy;
  logic            w_md_done;
  logic [XLEN-1:0] w_md_result;

  // Operand forwarding (MEM outranks WB) and ALU B-operand selection
  always_comb begin
    w_op_a     = i_fwd_a[1] ? i_fwd_mem_data : (i_fwd_a[0] ? i_fwd_wb_data : i_rs1_data);
    w_op_b_raw = i_fwd_b[1] ? i_fwd_mem_data : (i_fwd_b[0] ? i_fwd_wb_data : i_rs2_data);
    w_op_b     = i_alu_src_b_sel[1] ? i_pc_plus4 : (i_alu_src_b_sel[0] ? i_imm : w_op_b_raw);
  end

  // Branch condition on forwarded data; reserved funct3 values never take
  always_comb begin
    w_cond = 1'b0;
    case (i_funct3)
      F3_BEQ:  w_cond = (w_op_a == w_op_b_raw);
      F3_BNE:  w_cond = (w_op_a != w_op_b_raw);
      F3_BLT:  w_cond = ($signed(w_op_a) <  $signed(w_op_b_raw));
      F3_BGE:  w_cond = ($signed(w_op_a) >= $signed(w_op_b_raw));
      F3_BLTU: w_cond = (w_op_a <  w_op_b_raw);
      F3_BGEU: w_cond = (w_op_a >= w_op_b_raw);
      default: w_cond = 1'b0;
    endcase
  end

  alu #(
    .XLEN     (XLEN),
    .ALU_OP_W (ALU_OP_W)
  ) u_alu (
    .i_op (i_alu_op),
    .i_a  (w_op_a),
    .i_b  (w_op_b),
    .o_y  (w_alu_result)
  );

  assign w_md_start = i_valid_in & i_md_op & ~i_flush & ~i_rst;

  md_unit #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_md (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_md_start),
    .i_flush  (i_flush),
    .i_funct3 (i_funct3),
    .i_a      (w_op_a),
    .i_b      (w_op_b_raw),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  // Flush/reset drop the stall immediately so the killed slot can be refilled
  assign o_stall            = w_md_busy & ~i_flush & ~i_rst;
  assign o_valid_out        = i_valid_in & ~i_flush & ~o_stall & ~i_rst;
  assign o_pc_next_sel      = i_valid_in & ~i_flush & ~i_rst & ~i_md_op & ~o_stall &
                              (i_jump | (i_branch & w_cond));
  assign o_branch_jump_addr = i_pc + i_imm;
  assign o_result           = w_md_done ? w_md_result : w_alu_result;
  assign o_write_data       = w_op_b_raw;

endmodule
